uart_tx_arbiter: RTL and testbench

- Shares one serial transmitter (8N1, start/tx_busy interface) between NUM_REQ byte producers.
- Round-robin arbitration per byte; sequences each transfer (launch, wait for busy, wait for done) before re-arbitrating.
- Sits between on-chip byte sources (command responder, debug logger, status reporter) and the transmitter block.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions used by the transmit arbiter,
// the transmitter and the receiver (byte width, baud timing, arbiter states).
package uart_pkg;

  localparam int UART_BYTE_W  = 8;

  // Baud timing shared by the transmitter and receiver.
  localparam int CLK_FREQ_HZ  = 50_000_000;
  localparam int BAUD_RATE    = 115_200;
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

  // Transfer sequencing states of the transmit arbiter.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Scans the eligible requests
// starting just above last_grant, wrapping modulo NUM_REQ, and reports the
// first hit. lock_mask removes requesters from consideration.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   last_grant,
  input  logic [NUM_REQ-1:0] lock_mask,
  output logic               any_req,
  output logic [REQ_W-1:0]   winner
);

  logic [NUM_REQ-1:0] eligible;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      assign eligible[gi] = req[gi] & lock_mask[gi];
    end
  endgenerate

  // First eligible requester after last_grant, wrapping around.
  always_comb begin
    logic [REQ_W-1:0] idx_w;
    any_req = 1'b0;
    winner  = '0;
    idx_w   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_w = REQ_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any_req && eligible[idx_w]) begin
        any_req = 1'b1;
        winner  = idx_w;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 transmitter between NUM_REQ byte producers.
// Each byte is a full launch / wait-busy / wait-done sequence; arbitration is
// round-robin per byte. Optional packet lock: define UART_TX_ARB_PKT_LOCK_EN to
// keep the grant on one requester until it delivers a byte with req_last=1.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [UART_BYTE_W-1:0]     tx_data,
  input  logic                       tx_busy,
  output logic [REQ_W-1:0]           grant_id,
  output logic                       active
);

  arb_state_t               state_reg;
  logic [REQ_W-1:0]         last_grant_reg;
  logic [NUM_REQ-1:0]       req_ready_reg;
  logic                     tx_start_reg;
  logic [UART_BYTE_W-1:0]   tx_data_reg;
  logic [REQ_W-1:0]         grant_id_reg;
  logic                     active_reg;

  logic [NUM_REQ-1:0]       lock_mask;
  logic                     any_req;
  logic [REQ_W-1:0]         winner;

`ifdef UART_TX_ARB_PKT_LOCK_EN
  logic                     lock_reg;
  // While a packet is open only its owner may win arbitration.
  assign lock_mask = lock_reg ? (NUM_REQ'(1) << grant_id_reg) : '1;
`else
  logic                     unused_last;
  assign lock_mask   = '1;
  assign unused_last = ^req_last;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .lock_mask  (lock_mask),
    .any_req    (any_req),
    .winner     (winner)
  );

  // Transfer sequencer with registered outputs; start/ready pulse in LAUNCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= REQ_W'(NUM_REQ - 1);
      req_ready_reg  <= '0;
      tx_start_reg   <= 1'b0;
      tx_data_reg    <= '0;
      grant_id_reg   <= '0;
      active_reg     <= 1'b0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
      lock_reg       <= 1'b0;
`endif
    end else begin
      tx_start_reg  <= 1'b0;
      req_ready_reg <= '0;
      case (state_reg)
        IDLE: begin
          // A still-busy transmitter (e.g. after a reset) blocks the launch.
          if (any_req && !tx_busy) begin
            tx_data_reg    <= req_data[int'(winner)*UART_BYTE_W +: UART_BYTE_W];
            grant_id_reg   <= winner;
            last_grant_reg <= winner;
            tx_start_reg   <= 1'b1;
            req_ready_reg  <= NUM_REQ'(1) << winner;
            active_reg     <= 1'b1;
            state_reg      <= LAUNCH;
          end
        end
        LAUNCH: begin
`ifdef UART_TX_ARB_PKT_LOCK_EN
          // The accepted byte decides whether the packet stays open.
          lock_reg  <= ~req_last[grant_id_reg];
`endif
          state_reg <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state_reg <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            active_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign tx_start  = tx_start_reg;
  assign tx_data   = tx_data_reg;
  assign grant_id  = grant_id_reg;
  assign active    = active_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a small
// transmitter model (configurable busy delay/length) and queued producers.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int REQ_W   = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [8*NUM_REQ-1:0]   req_data = '0;
  logic [NUM_REQ-1:0]     req_last = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   tx_start;
  logic [7:0]             tx_data;
  logic                   tx_busy;
  logic [REQ_W-1:0]       grant_id;
  logic                   active;

  // Transmitter model controls/state.
  logic model_busy = 1'b0;
  logic stuck_busy = 1'b0;
  int   busy_delay = 0;
  int   busy_len   = 10;
  int   dcnt = 0;
  int   bcnt = 0;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0]       src_q[NUM_REQ][$];
  logic [REQ_W-1:0] log_id[$];
  logic [7:0]       log_data[$];
  logic [REQ_W-1:0] exp_id[$];
  logic [7:0]       exp_data[$];

  assign tx_busy = model_busy | stuck_busy;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises busy_delay cycles after the start pulse
  // and stays high for busy_len cycles. It ignores the arbiter reset.
  always @(posedge clk) begin
    if (tx_start) begin
      if (busy_delay == 0) begin
        model_busy <= 1'b1;
        bcnt       <= busy_len;
        dcnt       <= 0;
      end else begin
        dcnt <= busy_delay;
      end
    end else if (dcnt > 0) begin
      if (dcnt == 1) begin
        model_busy <= 1'b1;
        bcnt       <= busy_len;
      end
      dcnt <= dcnt - 1;
    end else if (model_busy) begin
      if (bcnt <= 1) model_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Present each producer's queue head on its request lines.
  task automatic drive();
    logic [8:0] h;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = h[7:0];
        req_last[i]        = h[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: monitor at the falling edge, pop accepted bytes after the
  // rising edge. Returns at posedge+1.
  task automatic tick();
    logic [NUM_REQ-1:0] rdy;
    @(negedge clk);
    chk("ready_with_start", 32'(req_ready != '0), 32'(tx_start));
    if (tx_start) begin
      log_id.push_back(grant_id);
      log_data.push_back(tx_data);
      $display("launch: grant_id=%0d tx_data=%02h t=%0t", grant_id, tx_data, $time);
      chk("ready_onehot", 32'(req_ready), 32'(1) << grant_id);
      chk("launch_tx_idle", 32'(tx_busy), 32'd0);
      chk("launch_active", 32'(active), 32'd1);
    end
    rdy = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rdy[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    drive();
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(all_empty() && !active && !tx_busy && dcnt == 0) && n < 500) begin
      tick();
      n++;
    end
    chk({tag, "_done_in_time"}, 32'(n < 500), 32'd1);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!tx_start && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_start_seen"}, 32'(tx_start), 32'd1);
  endtask

  task automatic expect_tx(input logic [REQ_W-1:0] id, input logic [7:0] d);
    exp_id.push_back(id);
    exp_data.push_back(d);
  endtask

  task automatic check_log(input string tag);
    int n;
    chk({tag, "_count"}, 32'(log_id.size()), 32'(exp_id.size()));
    n = (log_id.size() < exp_id.size()) ? log_id.size() : exp_id.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_grant%0d", tag, i), 32'(log_id[i]), 32'(exp_id[i]));
      chk($sformatf("%s_data%0d", tag, i), 32'(log_data[i]), 32'(exp_data[i]));
    end
    log_id.delete(); log_data.delete();
    exp_id.delete(); exp_data.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive();
    tick();
    tick();
    rst_n = 1'b1;
    log_id.delete(); log_data.delete();
  endtask

  initial begin
    drive();
    tick();
    // Reset values
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single byte from requester 0: latency and pulse shape.
    src_q[0].push_back({1'b0, 8'hA5});
    drive();
    chk("a_no_start_yet", 32'(tx_start), 32'd0);
    tick();
    chk("a_start", 32'(tx_start), 32'd1);
    chk("a_ready", 32'(req_ready), 32'b0001);
    chk("a_data", 32'(tx_data), 32'hA5);
    chk("a_grant", 32'(grant_id), 32'd0);
    chk("a_active", 32'(active), 32'd1);
    tick();
    chk("a_start_pulse", 32'(tx_start), 32'd0);
    chk("a_ready_pulse", 32'(req_ready), 32'd0);
    chk("a_active_hold", 32'(active), 32'd1);
    wait_idle("a");
    chk("a_active_clear", 32'(active), 32'd0);
    log_id.delete(); log_data.delete();

    // All four valid: rotation 0,1,2,3,0.
    do_reset();
    busy_delay = 0; busy_len = 10;
    src_q[0].push_back({1'b0, 8'h10});
    src_q[0].push_back({1'b0, 8'h14});
    src_q[1].push_back({1'b0, 8'h11});
    src_q[2].push_back({1'b0, 8'h12});
    src_q[3].push_back({1'b0, 8'h13});
    drive();
    wait_idle("rr");
    expect_tx(0, 8'h10); expect_tx(1, 8'h11); expect_tx(2, 8'h12);
    expect_tx(3, 8'h13); expect_tx(0, 8'h14);
    check_log("rr");

    // Late busy: arbiter must hold in WAIT_BUSY with active high.
    do_reset();
    busy_delay = 3; busy_len = 4;
    src_q[2].push_back({1'b0, 8'h3C});
    drive();
    wait_start("late");
    src_q[3].push_back({1'b0, 8'h7E});
    drive();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("late_no_start%0d", k), 32'(tx_start), 32'd0);
      chk($sformatf("late_active%0d", k), 32'(active), 32'd1);
    end
    wait_idle("late");
    expect_tx(2, 8'h3C); expect_tx(3, 8'h7E);
    check_log("late");
    busy_delay = 0;

    // Busy stuck high across reset release blocks the launch.
    stuck_busy = 1'b1;
    rst_n = 1'b0;
    src_q[1].push_back({1'b0, 8'h55});
    drive();
    tick();
    tick();
    rst_n = 1'b1;
    log_id.delete(); log_data.delete();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("stuck_hold%0d", k), 32'(tx_start), 32'd0);
    end
    stuck_busy = 1'b0;
    wait_idle("stuck");
    expect_tx(1, 8'h55);
    check_log("stuck");

    // Reset in WAIT_DONE: outputs clear at once, priority returns to 0.
    do_reset();
    busy_len = 10;
    src_q[2].push_back({1'b0, 8'h99});
    drive();
    wait_start("mid");
    tick();
    tick();
    tick();
    chk("mid_grant_pre", 32'(grant_id), 32'd2);
    chk("mid_active_pre", 32'(active), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_start", 32'(tx_start), 32'd0);
    chk("mid_rst_active", 32'(active), 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd0);
    chk("mid_rst_data", 32'(tx_data), 32'd0);
    tick();
    rst_n = 1'b1;
    log_id.delete(); log_data.delete();
    src_q[0].push_back({1'b0, 8'hA0});
    src_q[3].push_back({1'b0, 8'hB3});
    drive();
    wait_idle("mid");
    expect_tx(0, 8'hA0); expect_tx(3, 8'hB3);
    check_log("mid");

    // Packet of three from requester 1 competing with requester 2.
    do_reset();
    busy_len = 3;
    src_q[1].push_back({1'b0, 8'h21});
    src_q[1].push_back({1'b0, 8'h22});
    src_q[1].push_back({1'b1, 8'h23});
    src_q[2].push_back({1'b1, 8'h31});
    src_q[2].push_back({1'b1, 8'h32});
    drive();
    wait_idle("pkt");
`ifdef UART_TX_ARB_PKT_LOCK_EN
    expect_tx(1, 8'h21); expect_tx(1, 8'h22); expect_tx(1, 8'h23);
    expect_tx(2, 8'h31); expect_tx(2, 8'h32);
`else
    expect_tx(1, 8'h21); expect_tx(2, 8'h31); expect_tx(1, 8'h22);
    expect_tx(2, 8'h32); expect_tx(1, 8'h23);
`endif
    check_log("pkt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
